// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and edge-selection helper for the SPI slave receive stage
package spi_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_rx_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Leading edge is rising for cpol=0 and falling for cpol=1; cpha picks
    // whether data is sampled on the leading or the trailing edge.
    function automatic logic sample_edge(input spi_mode_t mode, input logic rise, input logic fall);
        logic lead;
        logic trail;
        lead  = mode.cpol ? fall : rise;
        trail = mode.cpol ? rise : fall;
        return mode.cpha ? trail : lead;
    endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - single-bit multi-flop synchronizer with selectable reset value
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset; loads RESET_VAL into every stage
//   d      asynchronous input
//   q      synchronized output
module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_frame_rx.sv
// rtl/spi_slave_frame_rx.sv - oversampling SPI slave that assembles MSB-first bytes into frames
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   cpol, cpha          SPI mode, latched when ssn falls
//   sclk, mosi, ssn     SPI pins from the master (asynchronous to clk)
//   miso                SPI data out, 0 while not selected
//   tx_data             byte shifted out on miso, loaded at each byte start
//   byte_data/valid     last completed byte, one-cycle pulse on update
//   frame_data/valid    last completed frame (first byte in MSBs), one-cycle pulse
//   frame_err           one-cycle pulse when ssn rises on a partial frame
module spi_slave_frame_rx
    import spi_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int FRAME_BYTES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          sclk,
    input  logic                          mosi,
    input  logic                          ssn,
    output logic                          miso,
    input  logic [DATA_W-1:0]             tx_data,
    output logic [DATA_W-1:0]             byte_data,
    output logic                          byte_valid,
    output logic [DATA_W*FRAME_BYTES-1:0] frame_data,
    output logic                          frame_valid,
    output logic                          frame_err
);

    localparam int FRAME_W = DATA_W * FRAME_BYTES;
    localparam int BIT_CW  = $clog2(DATA_W + 1);
    localparam int BYTE_CW = $clog2(FRAME_BYTES + 1);

    logic sclk_s, mosi_s, ssn_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ssn (
        .clk(clk), .reset(reset), .d(ssn), .q(ssn_s)
    );

    // One register after the synchronizers plus a delayed copy for edge
    // detection. mosi and ssn ride the same pipeline as sclk so that data and
    // select stay aligned with the clock edge that qualifies them.
    logic sclk_r, sclk_rr, mosi_r, ssn_r, ssn_rr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_r  <= 1'b0;
            sclk_rr <= 1'b0;
            mosi_r  <= 1'b0;
            ssn_r   <= 1'b1;
            ssn_rr  <= 1'b1;
        end else begin
            sclk_r  <= sclk_s;
            sclk_rr <= sclk_r;
            mosi_r  <= mosi_s;
            ssn_r   <= ssn_s;
            ssn_rr  <= ssn_r;
        end
    end

    logic sclk_rise, sclk_fall, ssn_fall, ssn_rise;
    assign sclk_rise = sclk_r & ~sclk_rr;
    assign sclk_fall = ~sclk_r & sclk_rr;
    assign ssn_fall  = ~ssn_r & ssn_rr;
    assign ssn_rise  = ssn_r & ~ssn_rr;

    spi_rx_state_t state, state_next;
    spi_mode_t     mode_q, shift_mode;
    logic          sample_ev, shift_ev;
    logic          start, stop, do_sample, do_shift;

    // The shift edge is simply the sample edge of the opposite phase.
    always_comb begin
        shift_mode      = mode_q;
        shift_mode.cpha = ~mode_q.cpha;
        sample_ev       = sample_edge(mode_q, sclk_rise, sclk_fall);
        shift_ev        = sample_edge(shift_mode, sclk_rise, sclk_fall);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ssn rising has priority: a sample edge in the same cycle is dropped.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        stop       = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        case (state)
            IDLE: begin
                if (ssn_fall) begin
                    state_next = ACTIVE;
                    start      = 1'b1;
                end
            end
            ACTIVE: begin
                if (ssn_rise) begin
                    state_next = IDLE;
                    stop       = 1'b1;
                end else begin
                    do_sample = sample_ev;
                    do_shift  = shift_ev;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    logic [BIT_CW-1:0]  bit_cnt;
    logic [BYTE_CW-1:0] byte_cnt;
    logic [DATA_W-1:0]  rx_shift, tx_shift, new_byte;
    logic [FRAME_W-1:0] frame_shift, frame_next;
    logic               byte_last, frame_last;

    assign new_byte   = {rx_shift[DATA_W-2:0], mosi_r};
    assign frame_next = FRAME_W'({frame_shift, new_byte});
    assign byte_last  = (bit_cnt == BIT_CW'(DATA_W - 1));
    assign frame_last = (byte_cnt == BYTE_CW'(FRAME_BYTES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= '0;
            bit_cnt     <= '0;
            byte_cnt    <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            frame_shift <= '0;
            miso        <= 1'b0;
            byte_data   <= '0;
            byte_valid  <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (start) begin
                bit_cnt     <= '0;
                byte_cnt    <= '0;
                mode_q.cpol <= cpol;
                mode_q.cpha <= cpha;
                // cpha=0 drives the MSB immediately, so the register keeps
                // only the bits still to come; cpha=1 waits for the first
                // shift edge to present the MSB.
                if (cpha) begin
                    tx_shift <= tx_data;
                    miso     <= 1'b0;
                end else begin
                    tx_shift <= {tx_data[DATA_W-2:0], 1'b0};
                    miso     <= tx_data[DATA_W-1];
                end
            end

            if (stop) begin
                miso     <= 1'b0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
                if ((bit_cnt != '0) || (byte_cnt != '0)) begin
                    frame_err <= 1'b1;
                end
            end

            if (do_shift) begin
                miso     <= tx_shift[DATA_W-1];
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (do_sample) begin
                rx_shift <= new_byte;
                if (byte_last) begin
                    bit_cnt    <= '0;
                    byte_data  <= new_byte;
                    byte_valid <= 1'b1;
                    tx_shift   <= tx_data;
                    if (frame_last) begin
                        byte_cnt    <= '0;
                        frame_data  <= frame_next;
                        frame_valid <= 1'b1;
                    end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                    frame_shift <= frame_next;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// tb/tb_spi_slave_frame_rx.sv - directed table-driven bench for spi_slave_frame_rx
`timescale 1ns/1ps
module tb_spi_slave_frame_rx;

    localparam int H = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpol = 1'b0, cpha = 1'b0;
    logic        sclk = 1'b0, mosi = 1'b0, ssn = 1'b1;
    logic        miso;
    logic [7:0]  tx_data = 8'h00;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic [15:0] frame_data;
    logic        frame_valid;
    logic        frame_err;

    spi_slave_frame_rx dut (
        .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha),
        .sclk(sclk), .mosi(mosi), .ssn(ssn), .miso(miso),
        .tx_data(tx_data),
        .byte_data(byte_data), .byte_valid(byte_valid),
        .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  byte_log [256];
    logic [15:0] frame_log [64];
    int          byte_n = 0, frame_n = 0, err_n = 0;

    always @(negedge clk) begin
        if (byte_valid && byte_n < 256) begin
            byte_log[byte_n] = byte_data;
            byte_n++;
        end
        if (frame_valid && frame_n < 64) begin
            frame_log[frame_n] = frame_data;
            frame_n++;
        end
        if (frame_err) err_n++;
    end

    int n_vec = 0, n_mis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic m_cpol = 1'b0, m_cpha = 1'b0;

    task automatic spi_begin(input logic pol, input logic pha);
        m_cpol = pol;
        m_cpha = pha;
        cpol   = pol;
        cpha   = pha;
        sclk   = pol;
        #(H);
        ssn = 1'b0;
        #(H);
    endtask

    task automatic spi_bits(input logic [7:0] d, input int n, output logic [7:0] m);
        m = '0;
        for (int i = 0; i < n; i++) begin
            if (!m_cpha) begin
                mosi = d[7-i];
                #(H);
                m = {m[6:0], miso};
                sclk = ~m_cpol;
                #(H);
                sclk = m_cpol;
            end else begin
                sclk = ~m_cpol;
                mosi = d[7-i];
                #(H);
                m = {m[6:0], miso};
                sclk = m_cpol;
                #(H);
            end
        end
    endtask

    task automatic spi_end();
        #(H);
        ssn = 1'b1;
        #(2*H);
    endtask

    typedef struct {
        logic        pol;
        logic        pha;
        logic [7:0]  tx;
        logic [7:0]  b0;
        logic [7:0]  b1;
        logic [15:0] frame;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] m0, m1, mx;
        logic [7:0] b2b [6];
        int bb, fb, eb;

        vecs[0] = '{pol: 1'b0, pha: 1'b0, tx: 8'h5A, b0: 8'hA5, b1: 8'h3C, frame: 16'hA53C};
        vecs[1] = '{pol: 1'b0, pha: 1'b1, tx: 8'h96, b0: 8'hA5, b1: 8'h3C, frame: 16'hA53C};
        vecs[2] = '{pol: 1'b1, pha: 1'b0, tx: 8'h96, b0: 8'hA5, b1: 8'h3C, frame: 16'hA53C};
        vecs[3] = '{pol: 1'b1, pha: 1'b1, tx: 8'h96, b0: 8'hA5, b1: 8'h3C, frame: 16'hA53C};
        b2b = '{8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_byte_data", 32'(byte_data), 32'h0);
        check("rst_byte_valid", 32'(byte_valid), 32'h0);
        check("rst_frame_data", 32'(frame_data), 32'h0);
        check("rst_frame_valid", 32'(frame_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // partial frame: one byte plus three bits
        bb = byte_n; fb = frame_n; eb = err_n;
        tx_data = 8'h00;
        spi_begin(1'b0, 1'b0);
        spi_bits(8'h12, 8, mx);
        spi_bits(8'hA0, 3, mx);
        spi_end();
        check("part_byte_cnt", 32'(byte_n - bb), 32'd1);
        check("part_byte_val", 32'(byte_log[bb]), 32'h12);
        check("part_frame_cnt", 32'(frame_n - fb), 32'd0);
        check("part_err_cnt", 32'(err_n - eb), 32'd1);
        check("part_frame_data", 32'(frame_data), 32'h0);
        check("part_byte_data", 32'(byte_data), 32'h12);

        // one frame in each SPI mode
        for (int v = 0; v < 4; v++) begin
            bb = byte_n; fb = frame_n; eb = err_n;
            tx_data = vecs[v].tx;
            spi_begin(vecs[v].pol, vecs[v].pha);
            spi_bits(vecs[v].b0, 8, m0);
            spi_bits(vecs[v].b1, 8, m1);
            spi_end();
            check($sformatf("m%0d_byte_cnt", v), 32'(byte_n - bb), 32'd2);
            check($sformatf("m%0d_byte0", v), 32'(byte_log[bb]), 32'(vecs[v].b0));
            check($sformatf("m%0d_byte1", v), 32'(byte_log[bb+1]), 32'(vecs[v].b1));
            check($sformatf("m%0d_frame_cnt", v), 32'(frame_n - fb), 32'd1);
            check($sformatf("m%0d_frame", v), 32'(frame_log[fb]), 32'(vecs[v].frame));
            check($sformatf("m%0d_frame_port", v), 32'(frame_data), 32'(vecs[v].frame));
            check($sformatf("m%0d_err", v), 32'(err_n - eb), 32'd0);
            check($sformatf("m%0d_miso0", v), 32'(m0), 32'(vecs[v].tx));
            check($sformatf("m%0d_miso1", v), 32'(m1), 32'(vecs[v].tx));
            check($sformatf("m%0d_miso_idle", v), 32'(miso), 32'h0);
        end

        // three frames back to back under a single select
        bb = byte_n; fb = frame_n; eb = err_n;
        spi_begin(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) spi_bits(b2b[i], 8, mx);
        spi_end();
        check("b2b_byte_cnt", 32'(byte_n - bb), 32'd6);
        check("b2b_frame_cnt", 32'(frame_n - fb), 32'd3);
        check("b2b_frame0", 32'(frame_log[fb]), 32'h0001);
        check("b2b_frame1", 32'(frame_log[fb+1]), 32'h0002);
        check("b2b_frame2", 32'(frame_log[fb+2]), 32'h0003);
        check("b2b_err", 32'(err_n - eb), 32'd0);

        // mode pins change mid-frame; master stays in mode 0
        bb = byte_n; fb = frame_n; eb = err_n;
        spi_begin(1'b0, 1'b0);
        spi_bits(8'hC3, 8, mx);
        cpol = 1'b1;
        cpha = 1'b1;
        spi_bits(8'h81, 8, mx);
        spi_end();
        check("modechg_frame_cnt", 32'(frame_n - fb), 32'd1);
        check("modechg_frame", 32'(frame_log[fb]), 32'hC381);
        check("modechg_err", 32'(err_n - eb), 32'd0);

        // sclk activity while deselected
        bb = byte_n; fb = frame_n; eb = err_n;
        for (int i = 0; i < 20; i++) begin
            mosi = i[0];
            sclk = ~sclk;
            #(H);
        end
        sclk = 1'b0;
        #(2*H);
        check("unsel_byte_cnt", 32'(byte_n - bb), 32'd0);
        check("unsel_frame_cnt", 32'(frame_n - fb), 32'd0);
        check("unsel_err", 32'(err_n - eb), 32'd0);
        check("unsel_miso", 32'(miso), 32'h0);

        // reset after 11 bits, then a clean frame
        spi_begin(1'b0, 1'b0);
        spi_bits(8'hFF, 8, mx);
        spi_bits(8'hE0, 3, mx);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("arst_byte_data", 32'(byte_data), 32'h0);
        check("arst_frame_data", 32'(frame_data), 32'h0);
        check("arst_valids", 32'({byte_valid, frame_valid, frame_err}), 32'h0);
        check("arst_miso", 32'(miso), 32'h0);
        ssn  = 1'b1;
        sclk = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        bb = byte_n; fb = frame_n; eb = err_n;
        spi_begin(1'b0, 1'b0);
        spi_bits(8'h00, 8, mx);
        spi_bits(8'h42, 8, mx);
        spi_end();
        check("post_rst_byte_cnt", 32'(byte_n - bb), 32'd2);
        check("post_rst_frame_cnt", 32'(frame_n - fb), 32'd1);
        check("post_rst_frame", 32'(frame_log[fb]), 32'h0042);
        check("post_rst_err", 32'(err_n - eb), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
